// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_SAVE     = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_MRET     = 3'd4
  } trap_state_e;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // Handler address; reserved modes (2, 3) fall back to direct.
  function automatic logic [31:0] trap_vector(input logic [31:0] mtvec,
                                              input logic [3:0]  code);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (mtvec[1:0] == MTVEC_VECTORED)
      return base + {26'b0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority interrupt cause encoder: external wins over timer.
module irq_prio_enc
  import trap_pkg::*;
(
  input  logic       req_ext,
  input  logic       req_timer,
  output logic       valid,
  output logic [3:0] code
);

  // Select the highest-priority enabled request.
  always_comb begin
    valid = req_ext | req_timer;
    code  = 4'd0;
    if (req_ext)
      code = CAUSE_MEI;
    else if (req_timer)
      code = CAUSE_MTI;
  end

endmodule

// File: rtl/trap_ctrl.sv
// Interrupt entry / MRET sequencer between the execute stage and the CSR file.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | no trap activity; watch for pending interrupt or MRET
//   DRAIN    | interrupt pending, waiting for an unstalled valid EX slot
//   SAVE     | one cycle: flush, write mepc/mcause, clear MIE
//   REDIRECT | one cycle: flush and steer fetch to the trap vector
//   MRET     | one cycle: flush, steer fetch to mepc, restore MIE
module trap_ctrl
  import trap_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic        mstatus_mie,
  input  logic        mie_meie,
  input  logic        mie_mtie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_q,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_mret,
  input  logic        ex_stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        mepc_wr,
  output logic [31:0] mepc_wdata,
  output logic        mcause_wr,
  output logic [31:0] mcause_wdata,
  output logic        mstatus_trap,
  output logic        mstatus_mret,
  output logic        trap_busy
);

  trap_state_e state, state_nxt;
  logic [31:0] pc_q;
  logic [3:0]  code_q;
  logic        pending;
  logic [3:0]  irq_code;
  logic        capture;
  logic        unused_pc_lsbs;

  // Global enable folded into the masked requests so valid is the pending flag.
  irq_prio_enc u_prio (
    .req_ext   (mstatus_mie & irq_ext & mie_meie),
    .req_timer (mstatus_mie & irq_timer & mie_mtie),
    .valid     (pending),
    .code      (irq_code)
  );

  // mepc is always word aligned, so the low PC bits are never written out.
  assign unused_pc_lsbs = ^pc_q[1:0];

  // State register and capture of the interrupted PC and cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      pc_q   <= 32'd0;
      code_q <= 4'd0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        pc_q   <= ex_pc;
        code_q <= irq_code;
      end
    end
  end

  // Next-state decode and Moore outputs; reset forces every output low.
  always_comb begin
    state_nxt      = state;
    capture        = 1'b0;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    mepc_wr        = 1'b0;
    mepc_wdata     = 32'd0;
    mcause_wr      = 1'b0;
    mcause_wdata   = 32'd0;
    mstatus_trap   = 1'b0;
    mstatus_mret   = 1'b0;
    trap_busy      = (state != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (ex_valid && ex_is_mret && !ex_stall) begin
          state_nxt = ST_MRET;
        end else if (pending) begin
          if (ex_valid && !ex_stall) begin
            capture   = 1'b1;
            state_nxt = ST_SAVE;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!pending) begin
          state_nxt = ST_IDLE;
        end else if (ex_valid && !ex_stall) begin
          capture   = 1'b1;
          state_nxt = ST_SAVE;
        end
      end
      ST_SAVE: begin
        flush        = 1'b1;
        mepc_wr      = 1'b1;
        mepc_wdata   = {pc_q[31:2], 2'b00};
        mcause_wr    = 1'b1;
        mcause_wdata = {1'b1, 27'd0, code_q};
        mstatus_trap = 1'b1;
        state_nxt    = ST_REDIRECT;
      end
      ST_REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = trap_vector(mtvec, code_q);
        state_nxt      = ST_IDLE;
      end
      ST_MRET: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mepc_q;
        mstatus_mret   = 1'b1;
        state_nxt      = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (rst) begin
      capture        = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      mepc_wr        = 1'b0;
      mepc_wdata     = 32'd0;
      mcause_wr      = 1'b0;
      mcause_wdata   = 32'd0;
      mstatus_trap   = 1'b0;
      mstatus_mret   = 1'b0;
      trap_busy      = 1'b0;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Scoreboard bench for trap_ctrl: expected strobe cycles are queued as
// stimulus is applied and matched against every strobe cycle the DUT emits.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irq_ext = 1'b0, irq_timer = 1'b0;
  logic        mstatus_mie = 1'b0, mie_meie = 1'b0, mie_mtie = 1'b0;
  logic [31:0] mtvec = 32'd0, mepc_q = 32'd0, ex_pc = 32'd0;
  logic        ex_valid = 1'b0, ex_is_mret = 1'b0, ex_stall = 1'b0;
  logic        flush, redirect_valid, mepc_wr, mcause_wr;
  logic        mstatus_trap, mstatus_mret, trap_busy;
  logic [31:0] redirect_pc, mepc_wdata, mcause_wdata;

  typedef struct {
    logic        flush, rv, mepc_wr, mcause_wr, trap, mret;
    logic [31:0] rpc, mepc_d, mcause_d;
  } ev_t;

  ev_t sb[$];
  ev_t got;
  int  n_cmp = 0;
  int  n_mis = 0;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .mstatus_mie(mstatus_mie), .mie_meie(mie_meie), .mie_mtie(mie_mtie),
    .mtvec(mtvec), .mepc_q(mepc_q), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_is_mret(ex_is_mret), .ex_stall(ex_stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mepc_wr(mepc_wr), .mepc_wdata(mepc_wdata), .mcause_wr(mcause_wr),
    .mcause_wdata(mcause_wdata), .mstatus_trap(mstatus_trap),
    .mstatus_mret(mstatus_mret), .trap_busy(trap_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] exp_vector(input logic [31:0] tv, input logic [3:0] code);
    logic [31:0] b;
    b = tv & 32'hFFFF_FFFC;
    if (tv[1:0] == 2'd1) b = b + 32'(code) * 32'd4;
    return b;
  endfunction

  task automatic push_trap(input logic [31:0] pc, input logic [3:0] code, input logic [31:0] tv);
    ev_t e;
    e = '{flush:1'b1, rv:1'b0, mepc_wr:1'b1, mcause_wr:1'b1, trap:1'b1, mret:1'b0,
          rpc:32'd0, mepc_d:(pc & 32'hFFFF_FFFC), mcause_d:(32'h8000_0000 | 32'(code))};
    sb.push_back(e);
    e = '{flush:1'b1, rv:1'b1, mepc_wr:1'b0, mcause_wr:1'b0, trap:1'b0, mret:1'b0,
          rpc:exp_vector(tv, code), mepc_d:32'd0, mcause_d:32'd0};
    sb.push_back(e);
  endtask

  task automatic push_mret(input logic [31:0] epc);
    ev_t e;
    e = '{flush:1'b1, rv:1'b1, mepc_wr:1'b0, mcause_wr:1'b0, trap:1'b0, mret:1'b1,
          rpc:epc, mepc_d:32'd0, mcause_d:32'd0};
    sb.push_back(e);
  endtask

  task automatic quiesce();
    irq_ext = 1'b0; irq_timer = 1'b0; mstatus_mie = 1'b0;
    ex_valid = 1'b0; ex_stall = 1'b0; ex_is_mret = 1'b0;
  endtask

  // Single-cycle trap entry from IDLE with an unstalled EX instruction.
  task automatic run_trap(input logic [31:0] tv, input logic ext, input logic tim,
                          input logic [31:0] pc);
    mtvec = tv; mie_meie = 1'b1; mie_mtie = 1'b1;
    irq_ext = ext; irq_timer = tim; mstatus_mie = 1'b1;
    ex_valid = 1'b1; ex_pc = pc; ex_stall = 1'b0; ex_is_mret = 1'b0;
    push_trap(pc, ext ? 4'd11 : 4'd7, tv);
    tick();
    chk("busy_after_capture", 32'(trap_busy), 32'd1);
    quiesce();
    tick(3);
    chk("busy_after_trap", 32'(trap_busy), 32'd0);
  endtask

  // Monitor: strobe cycles are popped from the scoreboard, quiet cycles must be all zero.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_strobes", {26'd0, flush, redirect_valid, mepc_wr, mcause_wr,
                          mstatus_trap, mstatus_mret}, 32'd0);
      chk("rst_busy", 32'(trap_busy), 32'd0);
      chk("rst_data", redirect_pc | mepc_wdata | mcause_wdata, 32'd0);
    end else if (flush | redirect_valid | mepc_wr | mcause_wr | mstatus_trap | mstatus_mret) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("flush", 32'(flush), 32'(got.flush));
        chk("redirect_valid", 32'(redirect_valid), 32'(got.rv));
        chk("redirect_pc", redirect_pc, got.rpc);
        chk("mepc_wr", 32'(mepc_wr), 32'(got.mepc_wr));
        chk("mepc_wdata", mepc_wdata, got.mepc_d);
        chk("mcause_wr", 32'(mcause_wr), 32'(got.mcause_wr));
        chk("mcause_wdata", mcause_wdata, got.mcause_d);
        chk("mstatus_trap", 32'(mstatus_trap), 32'(got.trap));
        chk("mstatus_mret", 32'(mstatus_mret), 32'(got.mret));
      end
    end else begin
      chk("quiet_data", redirect_pc | mepc_wdata | mcause_wdata, 32'd0);
    end
  end

  initial begin
    logic [31:0] tv_tab [4];
    logic [31:0] pc_tab [4];
    logic [1:0]  src_tab [4];
    tv_tab[0] = 32'h0000_0100; pc_tab[0] = 32'h0000_0040; src_tab[0] = 2'b01;
    tv_tab[1] = 32'h0000_0201; pc_tab[1] = 32'h0000_0300; src_tab[1] = 2'b11;
    tv_tab[2] = 32'hFFFF_FFFD; pc_tab[2] = 32'h0000_1003; src_tab[2] = 2'b10;
    tv_tab[3] = 32'h0000_0302; pc_tab[3] = 32'h0000_0556; src_tab[3] = 2'b01;

    tick(3);
    rst = 1'b0;
    tick();
    chk("busy_idle_after_reset", 32'(trap_busy), 32'd0);

    // Direct timer, simultaneous vectored, vectored wraparound, reserved mode.
    foreach (tv_tab[i]) run_trap(tv_tab[i], src_tab[i][1], src_tab[i][0], pc_tab[i]);

    // Drain through a 3-cycle stall; external joins at capture and wins.
    mtvec = 32'h100; mie_mtie = 1'b1; mie_meie = 1'b1; mstatus_mie = 1'b1;
    irq_timer = 1'b1; ex_valid = 1'b1; ex_stall = 1'b1; ex_pc = 32'h60;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("busy_drain", 32'(trap_busy), 32'd1);
    end
    ex_stall = 1'b0; ex_pc = 32'h80; irq_ext = 1'b1;
    push_trap(32'h80, 4'd11, 32'h100);
    tick();
    quiesce();
    tick(3);

    // Drain abandoned when the request drops mid-stall.
    mstatus_mie = 1'b1; irq_timer = 1'b1; ex_valid = 1'b1; ex_stall = 1'b1;
    tick();
    chk("busy_drain2", 32'(trap_busy), 32'd1);
    tick();
    irq_timer = 1'b0;
    tick();
    chk("busy_drain_abort", 32'(trap_busy), 32'd0);
    ex_stall = 1'b0;
    tick(3);
    quiesce();

    // MRET beats a pending interrupt in the same cycle.
    mepc_q = 32'h44; mstatus_mie = 1'b1; irq_timer = 1'b1;
    ex_valid = 1'b1; ex_is_mret = 1'b1; ex_pc = 32'h90;
    push_mret(32'h44);
    tick();
    quiesce();
    tick(3);

    // Global disable masks an asserted external request.
    mstatus_mie = 1'b0; irq_ext = 1'b1; mie_meie = 1'b1; ex_valid = 1'b1; ex_pc = 32'h10;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("busy_masked", 32'(trap_busy), 32'd0);
    end
    quiesce();
    tick();

    // Reset while in SAVE: no REDIRECT afterwards.
    mtvec = 32'h100; mstatus_mie = 1'b1; irq_timer = 1'b1; ex_valid = 1'b1; ex_pc = 32'h40;
    tick();
    quiesce();
    rst = 1'b1;
    tick();
    chk("busy_after_rst", 32'(trap_busy), 32'd0);
    rst = 1'b0;
    tick(4);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have ports irq_ext and irq_timer, input, 1 bit each: level-sensitive interrupt requests.
REQ-004 SHALL have ports mstatus_mie, mie_meie and mie_mtie, input, 1 bit each: current global and per-source enable bits from the CSR file.
REQ-005 SHALL have ports mtvec and mepc_q, input, 32 bits each: current CSR values.
REQ-006 SHALL have ports ex_valid (1), ex_pc (32), ex_is_mret (1) and ex_stall (1), all inputs: execute-stage occupancy, PC, MRET decode and hold.
REQ-007 SHALL have ports flush (1) and redirect_valid (1), outputs: squash IF/ID/EX; load the PC from redirect_pc.
REQ-008 SHALL have port redirect_pc, output, 32 bits: the fetch target.
REQ-009 SHALL have ports mepc_wr (1), mepc_wdata (32), mcause_wr (1) and mcause_wdata (32), outputs: CSR write strobes and data.
REQ-010 SHALL have ports mstatus_trap (1) and mstatus_mret (1), outputs.
- mstatus_trap pulse: the CSR file sets MPIE<=MIE, MIE<=0.
- mstatus_mret pulse: the CSR file sets MIE<=MPIE, MPIE<=1.
REQ-011 SHALL have port trap_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL implement states IDLE, DRAIN, SAVE, REDIRECT and MRET.
REQ-013 SHALL compute pending = mstatus_mie & ((irq_ext & mie_meie) | (irq_timer & mie_mtie)) combinationally.
REQ-014 SHALL select the cause as external (code 11) over timer (code 7) when both are enabled and asserted.
REQ-015 SHALL handle IDLE with ex_valid & ex_is_mret & !ex_stall by going to MRET; this has priority over pending in the same cycle.
REQ-016 SHALL handle IDLE with pending and an unstalled valid EX that is not MRET as follows:
- capture ex_pc and the cause into registers;
- go to SAVE.
REQ-017 SHALL handle IDLE with pending and (!ex_valid | ex_stall) by going to DRAIN.
REQ-018 SHALL handle DRAIN as follows:
- exit to IDLE if pending drops;
- otherwise capture and go to SAVE on the first cycle with ex_valid & !ex_stall.
- The cause SHALL be re-evaluated at the capture cycle.
REQ-019 SHALL hold SAVE for exactly one cycle, asserting all of:
- flush=1, mepc_wr=1, mepc_wdata={captured_pc[31:2],2'b00};
- mcause_wr=1, mcause_wdata={1'b1,27'b0,code[3:0]};
- mstatus_trap=1.
- Next state SHALL be REDIRECT.
REQ-020 SHALL hold REDIRECT for one cycle with redirect_valid=1 and flush=1, then go to IDLE.
REQ-021 SHALL form redirect_pc in REDIRECT as follows:
- mtvec[1:0]==0 (direct): {mtvec[31:2],2'b00};
- mtvec[1:0]==1 (vectored): {mtvec[31:2],2'b00} + 4*code, modulo 2^32;
- mtvec[1:0]>=2: treated as direct.
REQ-022 SHALL hold MRET for one cycle with redirect_valid=1, flush=1, redirect_pc=mepc_q and mstatus_mret=1, then go to IDLE.
REQ-023 SHALL hold all strobe outputs at 0 outside the states listed above; redirect_pc and mepc_wdata/mcause_wdata SHALL be 0 when not strobed.
REQ-024 SHALL give a latency of 2 cycles from the capture edge to redirect_valid, with no back-to-back trap possible because MIE is cleared in SAVE.
REQ-025 SHALL ignore an interrupt edge that deasserts before capture (level-sensitive, no latching).

Reset
REQ-026 SHALL put state IDLE, zero the captured PC/cause registers and drive every output 0 on rst.
REQ-027 SHALL let rst asserted in any state abort the sequence with no further CSR strobes.

Structure
REQ-028 SHALL define the state enum, cause codes (CAUSE_MEI=11, CAUSE_MTI=7) and mtvec mode constants in shared package trap_pkg.
REQ-029 SHALL put cause selection in sub-module irq_prio_enc (inputs: masked requests; outputs: valid and code).
REQ-030 SHALL instantiate no CSR storage; the CSR file remains the owner of its registers.

Verification
REQ-031 SHALL cover timer trap, direct mode:
- stimulus: mtvec=0x100, MIE=1, mtie=1, irq_timer=1, EX valid at pc=0x40;
- response: SAVE mepc_wdata=0x40, mcause_wdata=0x80000007; next cycle redirect_pc=0x100.
REQ-032 SHALL cover simultaneous sources, vectored mode:
- stimulus: both enabled, irq_ext=irq_timer=1, mtvec=0x201;
- response: mcause_wdata=0x8000000B, redirect_pc=0x22C.
REQ-033 SHALL cover DRAIN:
- stimulus: pending with ex_stall=1 for 3 cycles, then EX pc=0x80 unstalled;
- response: trap_busy during the stall, mepc_wdata=0x80; drop irq mid-stall -> IDLE with no strobes.
REQ-034 SHALL cover MRET priority:
- stimulus: ex_is_mret with pending same cycle, mepc_q=0x44;
- response: redirect_pc=0x44 and mstatus_mret=1; no mcause_wr that cycle.
REQ-035 SHALL cover masking: MIE=0 with irq_ext=1 -> no trap for 10 cycles.
REQ-036 SHALL cover reset: rst in SAVE -> outputs 0 next cycle, state IDLE, no REDIRECT.
